puf_challenge_driver: RTL and testbench

PUF_CHALLENGE_DRIVER -- requirements
Module: puf_challenge_driver

---
 rtl/puf_challenge_driver.sv | 130 +++++++++++++
 tb/tb_puf_challenge_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_driver.sv
// rtl/puf_challenge_driver.sv - arbiter PUF challenge sequencer and response collector
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start, seed         request pulse (sampled in IDLE only) and initial challenge
//   busy                high in every state except IDLE
//   challenge, launch   challenge vector and race edge driven to the arbiter chain
//   puf_resp            arbiter response bit, asynchronous to clk
//   resp_word           K collected response bits, bit i answers the i-th challenge
//   resp_valid          resp_word complete; held until resp_valid && resp_ready
//   resp_ready          consumer accept
module puf_challenge_driver #(
    parameter int N      = 128,
    parameter int K      = 32,
    parameter int SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] seed,
    output logic         busy,
    output logic [N-1:0] challenge,
    output logic         launch,
    input  logic         puf_resp,
    output logic [K-1:0] resp_word,
    output logic         resp_valid,
    input  logic         resp_ready
);

    localparam int BW = $clog2(K + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_FIRE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   bit_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [1:0]      resp_sync;     // resp_sync[1] is the synchronized response
    logic            settle_done;
    logic            last_bit;
    logic            fb;
    logic            launch_nxt;

    assign settle_done = (settle_cnt == SW'(SETTLE - 1));
    assign last_bit    = (bit_cnt == BW'(K - 1));
    assign fb          = challenge[N-1] ^ challenge[N-3] ^ challenge[N-28] ^ challenge[N-30];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_ARM;
            S_ARM:    if (settle_done) state_nxt = S_FIRE;
            S_FIRE:   if (settle_done) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = last_bit ? S_DONE : S_ARM;
            S_DONE:   if (resp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs; launch is decoded from the next state and registered so the
    // arbiter sees a clean edge aligned with the FIRE entry.
    always_comb begin
        busy       = (state != S_IDLE);
        resp_valid = (state == S_DONE);
        launch_nxt = (state_nxt == S_FIRE) || (state_nxt == S_SAMPLE);
    end

    // Datapath: synchronizer, counters, challenge LFSR, response shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_sync  <= '0;
            settle_cnt <= '0;
            bit_cnt    <= '0;
            challenge  <= '0;
            resp_word  <= '0;
            launch     <= 1'b0;
        end else begin
            resp_sync <= {resp_sync[0], puf_resp};
            launch    <= launch_nxt;

            // Counts cycles within ARM/FIRE; wraps to 0 on the phase change.
            if ((state == S_ARM || state == S_FIRE) && !settle_done) begin
                settle_cnt <= settle_cnt + SW'(1);
            end else begin
                settle_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        // An all-zero LFSR state would lock up, so substitute 1.
                        challenge <= (seed == '0) ? {{(N-1){1'b0}}, 1'b1} : seed;
                    end
                end
                S_LOAD: begin
                    bit_cnt   <= '0;
                    resp_word <= '0;
                end
                S_SAMPLE: begin
                    resp_word <= {resp_sync[1], resp_word[K-1:1]};
                    bit_cnt   <= bit_cnt + BW'(1);
                    if (!last_bit) begin
                        challenge <= {challenge[N-2:0], fb};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_driver.sv
// tb/tb_puf_challenge_driver.sv - self-checking bench for puf_challenge_driver
module tb_puf_challenge_driver;

    localparam int N      = 128;
    localparam int K      = 32;
    localparam int SETTLE = 4;
    localparam int BIT_T  = 2 * SETTLE + 1;
    localparam int RUN_T  = 1 + K * BIT_T;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] seed;
    logic         busy;
    logic [N-1:0] challenge;
    logic         launch;
    logic         puf_resp;
    logic [K-1:0] resp_word;
    logic         resp_valid;
    logic         resp_ready;

    int checks   = 0;
    int failures = 0;

    // Behavioural PUF: 0 const0, 1 const1, 2 challenge[tap], 3 parity(challenge & mask)
    int           pmode = 0;
    int           ptap  = 0;
    logic [N-1:0] pmask = '0;
    logic [N-1:0] seen_c [3];

    typedef struct {
        logic [N-1:0] seed;
        int           mode;
        int           tap;
        logic         early;
        int           hold;
        logic [K-1:0] expw;
    } vec_t;

    vec_t tbl [6];

    puf_challenge_driver #(.N(N), .K(K), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .busy       (busy),
        .challenge  (challenge),
        .launch     (launch),
        .puf_resp   (puf_resp),
        .resp_word  (resp_word),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic resp_fn(input logic [N-1:0] c, input int mode, input int tap,
                                     input logic [N-1:0] mask);
        logic r;
        case (mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            2:       r = c[tap];
            default: r = ^(c & mask);
        endcase
        return r;
    endfunction

    assign puf_resp = resp_fn(challenge, pmode, ptap, pmask);

    // Polynomial x^128+x^126+x^101+x^99+1 expressed as a left shift
    function automatic logic [N-1:0] next_chal(input logic [N-1:0] c);
        return {c[N-2:0], c[N-1] ^ c[N-3] ^ c[N-28] ^ c[N-30]};
    endfunction

    function automatic logic [N-1:0] rand_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full request from accept to handshake, checked against the model.
    task automatic run_req(input logic [N-1:0] s, input int mode, input int tap,
                           input logic [N-1:0] mask, input logic early, input int hold,
                           output logic [K-1:0] got);
        logic [N-1:0] c;
        logic [N-1:0] exp_c [K];
        logic [K-1:0] exp_w;
        int           cyc, pulses, hi, badlen, badchal, stuck;
        logic         prev, seen_valid;
        pmode = mode; ptap = tap; pmask = mask;
        c = (s == '0) ? N'(1) : s;
        for (int i = 0; i < K; i++) begin
            exp_c[i] = c;
            exp_w[i] = resp_fn(c, mode, tap, mask);
            c = next_chal(c);
        end
        resp_ready = early;
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seed  = rand_wide();
        check("busy_after_accept", busy, 1);
        cyc = 0; pulses = 0; hi = 0; badlen = 0; badchal = 0; prev = 0; seen_valid = 0;
        while (cyc < RUN_T + 20) begin
            @(posedge clk); #1;
            cyc++;
            if (launch && !prev) begin
                if (pulses < 3) seen_c[pulses] = challenge;
                if (pulses < K && challenge !== exp_c[pulses]) badchal++;
                pulses++;
                hi = 0;
            end
            if (launch) hi++;
            if (!launch && prev && hi != SETTLE + 1) badlen++;
            prev = launch;
            if (resp_valid) begin
                seen_valid = 1;
                break;
            end
        end
        got = resp_word;
        check("valid_seen", seen_valid, 1);
        check("latency", cyc, RUN_T);
        check("launch_pulses", pulses, K);
        check("launch_len_bad", badlen, 0);
        check("challenge_seq_bad", badchal, 0);
        check("resp_word_model", resp_word, exp_w);
        check("launch_in_done", launch, 0);
        check("challenge_in_done", challenge, exp_c[K-1]);
        if (early) begin
            @(posedge clk); #1;
            resp_ready = 1'b0;
            check("valid_drop_early", resp_valid, 0);
        end else begin
            stuck = 0;
            for (int i = 0; i < hold; i++) begin
                start = (i == 3);
                @(posedge clk); #1;
                if (!resp_valid || resp_word !== exp_w) stuck++;
            end
            check("hold_stable_bad", stuck, 0);
            resp_ready = 1'b1;
            start = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            start = 1'b0;
            check("valid_after_hs", resp_valid, 0);
            check("busy_after_hs", busy, 0);
            @(posedge clk); #1;
            check("idle_ignores_hs_start", busy, 0);
        end
    endtask

    task automatic wait_falls(input int n, output logic ok);
        int   f, t;
        logic p;
        f = 0; t = 0; p = launch;
        while (f < n && t < 2000) begin
            @(posedge clk); #1;
            t++;
            if (p && !launch) f++;
            p = launch;
        end
        ok = (f == n);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_launch", launch, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_challenge", challenge, 0);
        check("rst_resp_word", resp_word, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [K-1:0] got;
        logic         ok;
        int           t;

        tbl[0] = '{seed: N'(1),          mode: 1, tap: 0, early: 1'b0, hold: 10, expw: 32'hFFFFFFFF};
        tbl[1] = '{seed: N'(1),          mode: 2, tap: 0, early: 1'b0, hold: 2,  expw: 32'h00000001};
        tbl[2] = '{seed: N'(0),          mode: 2, tap: 0, early: 1'b0, hold: 2,  expw: 32'h00000001};
        tbl[3] = '{seed: N'(1),          mode: 0, tap: 0, early: 1'b1, hold: 0,  expw: 32'h00000000};
        tbl[4] = '{seed: N'(1),          mode: 2, tap: 5, early: 1'b0, hold: 1,  expw: 32'h00000020};
        tbl[5] = '{seed: N'(1) << (N-1), mode: 2, tap: 0, early: 1'b0, hold: 3,  expw: 32'h00000002};

        rst_n = 1'b0; start = 1'b0; seed = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_launch", launch, 0);
        check("reset_valid", resp_valid, 0);
        check("reset_challenge", challenge, 0);
        check("reset_resp_word", resp_word, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            run_req(tbl[v].seed, tbl[v].mode, tbl[v].tap, '0, tbl[v].early, tbl[v].hold, got);
            check("table_word", got, tbl[v].expw);
            if (v == 0) begin
                check("lfsr_first", seen_c[0], N'(1));
                check("lfsr_second", seen_c[1], N'(2));
                check("lfsr_third", seen_c[2], N'(4));
            end
            if (v == 2) check("zero_seed_first", seen_c[0], N'(1));
        end

        // Reset in the middle of FIRE with a partly filled response word
        pmode = 1;
        seed = N'(1); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_falls(3, ok);
        check("reach_bit3", ok, 1);
        t = 0;
        while (!launch && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("reach_fire", launch, 1);
        @(posedge clk); #1;
        apply_reset();

        // Reset after bit 10, then a fresh request depends only on the new seed
        pmode = 3; pmask = rand_wide();
        seed = rand_wide(); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_falls(10, ok);
        check("reach_bit10", ok, 1);
        apply_reset();
        run_req(rand_wide(), 3, 0, rand_wide(), 1'b0, 2, got);

        // Randomized requests against the model
        for (int r = 0; r < 6; r++) begin
            run_req(rand_wide(), $urandom_range(2, 3), $urandom_range(0, N-1), rand_wide(),
                    1'($urandom_range(0, 1)), $urandom_range(0, 4), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
